// File: rtl/tt_input_conditioner_if.sv
// tt_input_conditioner_if
//   Bundles the conditioner's input channels and its conditioned outputs.
//   master : drives ena/din/invert, observes dout/rise/fall/changed
//   slave  : the conditioner itself
//   Ports carried:
//     ena     - filter enable (1 bit)
//     din     - raw asynchronous inputs (WIDTH)
//     invert  - per-channel polarity select, 1 = invert (WIDTH)
//     dout    - debounced level (WIDTH)
//     rise    - one-cycle 0->1 pulse per channel (WIDTH)
//     fall    - one-cycle 1->0 pulse per channel (WIDTH)
//     changed - OR of all rise/fall bits (1 bit)
interface tt_input_conditioner_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] invert;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (
    output ena, din, invert,
    input  dout, rise, fall, changed
  );

  modport slave (
    input  ena, din, invert,
    output dout, rise, fall, changed
  );
endinterface

// File: rtl/tt_input_conditioner.sv
// tt_input_conditioner
//   WIDTH independent channels, each: synchroniser -> optional inversion ->
//   debounce filter -> registered level plus rise/fall edge pulses.
//   Ports:
//     clk   - system clock
//     rst_n - asynchronous active-low reset, clears every flop
//     bus   - tt_input_conditioner_if.slave (ena, din, invert in;
//             dout, rise, fall, changed out)
module tt_input_conditioner #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_COUNT    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tt_input_conditioner_if.slave  bus
);

  localparam int CNT_W = $clog2(DB_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;

  // Stage 0 captures din; the chain shifts every edge, independent of ena.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.din};

  // Inversion sits after the synchroniser, so a change of invert looks like
  // an input change and goes through the same debounce.
  assign sample = sync_q[SYNC_STAGES-1] ^ bus.invert;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             lvl_d;
      logic             rise_ch_d;
      logic             fall_ch_d;

      always_comb begin
        cnt_d     = cnt_q;
        lvl_d     = dout_q[gi];
        rise_ch_d = 1'b0;
        fall_ch_d = 1'b0;
        if (bus.ena) begin
          if (sample[gi] == dout_q[gi]) begin
            // Any agreeing sample throws away partial progress.
            cnt_d = '0;
          end else if (cnt_q == CNT_MAX) begin
            lvl_d     = sample[gi];
            cnt_d     = '0;
            rise_ch_d = sample[gi];
            fall_ch_d = ~sample[gi];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign dout_d[gi] = lvl_d;
      assign rise_d[gi] = rise_ch_d;
      assign fall_d[gi] = fall_ch_d;
    end
  endgenerate

  assign changed_d = |(rise_d | fall_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      dout_q    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      dout_q    <= dout_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.changed = changed_q;

endmodule

// File: tb/tb_tt_input_conditioner.sv
module tb_tt_input_conditioner;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int DB    = 4;

  typedef struct packed {
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  tt_input_conditioner_if #(.WIDTH(WIDTH)) bus ();

  tt_input_conditioner #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC),
    .DB_COUNT(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  // Each channel accepts a new level once the (synchronised, polarity
  // corrected) input has disagreed with the current level on DB enabled
  // edges in a row. The synchroniser is a plain SYNC-deep delay line.
  exp_t             exp_q[$];
  logic [WIDTH-1:0] m_line[SYNC];
  logic [WIDTH-1:0] m_level;
  int               m_disagree[WIDTH];

  always @(posedge clk) begin
    exp_t             e;
    logic [WIDTH-1:0] seen;
    e = '0;
    if (!rst_n) begin
      for (int k = 0; k < SYNC; k++) m_line[k] = '0;
      for (int c = 0; c < WIDTH; c++) m_disagree[c] = 0;
      m_level = '0;
    end else begin
      seen = m_line[SYNC-1] ^ bus.invert;
      if (bus.ena) begin
        for (int c = 0; c < WIDTH; c++) begin
          if (seen[c] != m_level[c]) begin
            m_disagree[c] = m_disagree[c] + 1;
            if (m_disagree[c] >= DB) begin
              m_level[c]    = seen[c];
              m_disagree[c] = 0;
              if (seen[c]) e.rise[c] = 1'b1;
              else         e.fall[c] = 1'b1;
            end
          end else begin
            m_disagree[c] = 0;
          end
        end
      end
      for (int k = SYNC - 1; k > 0; k--) m_line[k] = m_line[k-1];
      m_line[0] = bus.din;
    end
    e.dout    = m_level;
    e.changed = (e.rise != '0) || (e.fall != '0);
    exp_q.push_back(e);
  end

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.dout, bus.rise, bus.fall, bus.changed};
      checks = checks + 1;
      if (a !== e) begin
        errors = errors + 1;
        $display("FAIL scoreboard t=%0t got dout=%h rise=%h fall=%h changed=%b want dout=%h rise=%h fall=%h changed=%b",
                 $time, a.dout, a.rise, a.fall, a.changed, e.dout, e.rise, e.fall, e.changed);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks = checks + 1;
    if (act !== want) begin
      errors = errors + 1;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, want);
    end else begin
      $display("check %s t=%0t value=%h", name, $time, act);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; inputs change 1 time unit later.
  task automatic drive(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] inv, input logic en);
    #1;
    bus.din    = d;
    bus.invert = inv;
    bus.ena    = en;
  endtask

  initial begin
    logic [WIDTH-1:0] acc_rise;
    logic [WIDTH-1:0] acc_fall;
    logic             seen;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] inv;
    logic             en;

    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    bus.din    = '0;
    bus.invert = '0;
    bus.ena    = 1'b1;

    // Reset and idle
    wait_edges(3);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_edges(1);
      check("idle_all_zero", 32'({bus.dout, bus.rise, bus.fall, bus.changed}), 32'd0);
    end

    // Clean rising step on channel 0: new level on edge 6
    drive(8'h01, 8'h00, 1'b1);
    wait_edges(5);
    check("step_rise_edge5_dout", 32'(bus.dout), 32'h00);
    wait_edges(1);
    check("step_rise_edge6_dout", 32'(bus.dout), 32'h01);
    check("step_rise_edge6_rise", 32'({bus.rise, bus.fall, bus.changed}), {15'd0, 8'h01, 8'h00, 1'b1});
    wait_edges(1);
    check("step_rise_pulse_gone", 32'({bus.rise, bus.changed}), 32'd0);
    drive(8'h00, 8'h00, 1'b1);
    wait_edges(5);
    check("step_fall_edge5", 32'({bus.dout, bus.fall}), {16'd0, 8'h01, 8'h00});
    wait_edges(1);
    check("step_fall_edge6", 32'({bus.dout, bus.fall, bus.changed}), {15'd0, 8'h00, 8'h01, 1'b1});
    wait_edges(4);

    // Glitch rejection: 3-cycle pulse on channel 3 never reaches dout
    acc_rise = '0;
    acc_fall = '0;
    drive(8'h08, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_edges(1);
      acc_rise |= bus.rise; acc_fall |= bus.fall;
    end
    drive(8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      wait_edges(1);
      acc_rise |= bus.rise; acc_fall |= bus.fall;
    end
    check("glitch3_no_pulse", 32'({bus.dout, acc_rise, acc_fall}), 32'd0);

    // 4-cycle pulse is accepted, then released
    drive(8'h08, 8'h00, 1'b1);
    wait_edges(4);
    drive(8'h00, 8'h00, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      wait_edges(1);
      if (bus.rise[3]) seen = 1'b1;
    end
    check("pulse4_rise3", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      wait_edges(1);
      if (bus.fall[3]) seen = 1'b1;
    end
    check("pulse4_fall3", 32'(seen), 32'd1);
    wait_edges(4);

    // Inversion with settled synchroniser: new level after DB edges
    drive(8'h00, 8'h81, 1'b1);
    wait_edges(DB - 1);
    check("invert_before", 32'(bus.dout), 32'h00);
    wait_edges(1);
    check("invert_dout", 32'(bus.dout), 32'h81);
    check("invert_rise", 32'(bus.rise), 32'h81);
    drive(8'h00, 8'h00, 1'b1);
    wait_edges(8);

    // Enable freeze on channel 5 with the counter at 2
    drive(8'h20, 8'h00, 1'b1);
    wait_edges(4);
    drive(8'h20, 8'h00, 1'b0);
    acc_rise = '0;
    for (int i = 0; i < 10; i++) begin
      wait_edges(1);
      acc_rise |= bus.rise;
    end
    check("freeze_hold", 32'({bus.dout, acc_rise}), 32'd0);
    drive(8'h20, 8'h00, 1'b1);
    wait_edges(1);
    check("freeze_resume_edge1", 32'(bus.dout), 32'h00);
    wait_edges(1);
    check("freeze_resume_edge2", 32'({bus.dout, bus.rise}), {16'd0, 8'h20, 8'h20});
    wait_edges(2);

    // Reset mid-operation
    drive(8'hFF, 8'h00, 1'b1);
    wait_edges(10);
    check("all_high", 32'(bus.dout), 32'hFF);
    drive(8'hFD, 8'h00, 1'b1);
    wait_edges(5);
    #1;
    bus.din = 8'hFF;
    rst_n   = 1'b0;
    #1;
    check("reset_async_clear", 32'({bus.dout, bus.rise, bus.fall, bus.changed}), 32'd0);
    wait_edges(2);
    #1 rst_n = 1'b1;
    wait_edges(5);
    check("post_reset_edge5", 32'({bus.dout, bus.rise}), 32'd0);
    wait_edges(1);
    check("post_reset_edge6", 32'({bus.dout, bus.rise, bus.changed}), {7'd0, 8'hFF, 8'hFF, 1'b1});
    wait_edges(1);
    check("post_reset_pulse_gone", 32'({bus.rise, bus.changed}), 32'd0);

    // Randomised phase, checked only by the scoreboard
    d   = 8'hFF;
    inv = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 2) == 0) d[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
      if ($urandom_range(0, 59) == 0) inv[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        wait_edges($urandom_range(1, 3));
        #1 rst_n = 1'b1;
        wait_edges(1);
      end else begin
        drive(d, inv, en);
        wait_edges(1);
      end
    end

    drive(8'h00, 8'h00, 1'b1);
    wait_edges(12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_input_conditioner.md
Name: tt_input_conditioner

Overview:
- Parametrised successor to the single-pin pass-through on the Tiny Tapeout top.
- Conditions WIDTH independent input channels: synchroniser, optional per-channel inversion, debounce filter and rise/fall edge-pulse generation.
- Sits between the TT dedicated inputs (ui_in) and any downstream logic.
- Registered, clean levels and pulses drive uo_out or internal FSMs.

Parameters:
- WIDTH, 8: number of channels (1..8).
- SYNC_STAGES, 2: synchroniser flops per channel (2..4).
- DB_COUNT, 4: consecutive differing samples needed before the output level flips (1..255).
- CNT_W, $clog2(DB_COUNT+1): debounce counter width (derived, localparam).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  filter enable; low freezes debounce state.
- din  input  WIDTH  raw asynchronous inputs.
- invert  input  WIDTH  per-channel polarity select; 1 = invert. Quasi-static but may change at any time.
- dout  output  WIDTH  debounced, registered level.
- rise  output  WIDTH  one-cycle pulse when dout goes 0->1.
- fall  output  WIDTH  one-cycle pulse when dout goes 1->0.
- changed  output  1  registered OR of rise|fall.

Behaviour:
- Reset: rst_n low asynchronously clears all of the following to 0:
  - sync chains
  - counters
  - dout, rise, fall, changed
- Release of reset is synchronous to clk. The first sampling edge follows release.
- Sync chain: din[i] shifts through SYNC_STAGES flops every edge, regardless of ena.
- Sample: sample[i] = last sync stage XOR invert[i]. This is combinational and not synchronised.
  - A change on invert is treated exactly like an input change and is debounced.
- Per-channel debounce, each edge with ena=1:
  - sample==dout: cnt<=0; dout holds.
  - sample!=dout and cnt==DB_COUNT-1: dout<=sample; cnt<=0.
  - sample!=dout otherwise: cnt<=cnt+1.
- Glitch rejection: any sample matching dout before the threshold resets cnt. A pulse shorter than DB_COUNT sampled cycles never reaches dout.
- Latency: after a clean din step, dout changes on edge SYNC_STAGES+DB_COUNT. The first edge that captures the new value counts as edge 1.
- ena=0:
  - cnt and dout hold.
  - rise, fall and changed are 0 on the next edge.
  - Sync chain keeps running.
  - On re-enable, counting resumes from the held cnt.
- Edge pulses:
  - rise[i] and fall[i] are registered. They assert on the same edge dout[i] updates and last exactly one cycle.
  - rise and fall for one channel are never both high.
  - Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- changed: registered in the same cycle as the rise/fall pulses, i.e. high exactly when any rise or fall bit is high.
- DB_COUNT=1: dout follows sample one edge after it settles, with no filtering.
- Counter never exceeds DB_COUNT-1, so there is no wrap-around.
- Reset mid-count discards all partial debounce progress. No pulse is emitted on reset entry or exit.

Test Plan:
- Reset, defaults (WIDTH=8, SYNC_STAGES=2, DB_COUNT=4), din=0x00, invert=0x00, ena=1, hold 20 cycles:
  - Required: dout=0x00, rise=fall=0x00, changed=0 throughout.
- Clean step, din[0] 0->1 held stable:
  - Required: dout[0]=1 exactly on edge 6.
  - rise[0]=1 and changed=1 for exactly one cycle on edge 6; fall=0x00.
  - din 1->0 then gives fall[0] one cycle on edge 6 after the step.
- Glitch rejection, din[3] high for 3 cycles then low:
  - Required: dout[3] stays 0, no rise/fall pulses.
  - A 4-cycle high pulse must produce rise[3], then later fall[3].
- Inversion, din=0x00, invert 0x00->0x81:
  - Required: dout=0x81 after DB_COUNT edges (sync already settled).
  - rise=0x81 for one cycle.
- Enable freeze:
  - Stimulus: step din[5] 0->1; drop ena after cnt reaches 2; hold 10 cycles; re-raise ena.
  - Required: dout[5] stays 0 while ena=0; dout[5]=1 on the second edge after ena returns; one rise[5] pulse.
- Reset mid-operation:
  - Stimulus: assert rst_n low with cnt=3 on channel 1 and dout=0xFF; release.
  - Required: all outputs 0 immediately (asynchronous).
  - With din still 0xFF, dout=0xFF on edge 6 after release, with rise=0xFF for one cycle.
